// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack.
// Holds the default sizes, the stack command encoding and the command decode
// function. It is used by stack_unit_if, stack_ram and stack_unit.
// The optional feature macro STACK_ERR_EN is handled in the files that use this package.
package stack_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_TOS,
    OP_REPLACE
  } stack_op_t;

  // When push and pop are both set, the command is REPLACE and tos is ignored.
  // Otherwise push takes priority over pop, and pop takes priority over tos.
  function automatic stack_op_t decode_op(input logic push, input logic pop, input logic tos);
    if (push && pop) return OP_REPLACE;
    if (push)        return OP_PUSH;
    if (pop)         return OP_POP;
    if (tos)         return OP_TOS;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Command and data interface between the controller/datapath and the stack.
// Signals:
//   push, pop, tos - command strobes from the controller
//   din            - data to push
//   dout, dout_vld - registered read data, and a pulse that marks new read data
//   count, empty, full - stack occupancy
//   err_clr, overflow, underflow - present only when STACK_ERR_EN is defined
// Modports:
//   master - the controller side
//   slave  - the stack side
interface stack_unit_if
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
);
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic              tos;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic [PTR_W-1:0]  count;
  logic              empty;
  logic              full;
`ifdef STACK_ERR_EN
  logic              err_clr;
  logic              overflow;
  logic              underflow;
`endif

  modport master (
    output push, pop, tos, din,
`ifdef STACK_ERR_EN
    output err_clr,
    input  overflow, underflow,
`endif
    input  dout, dout_vld, count, empty, full
  );

  modport slave (
    input  push, pop, tos, din,
`ifdef STACK_ERR_EN
    input  err_clr,
    output overflow, underflow,
`endif
    output dout, dout_vld, count, empty, full
  );

endinterface

// File: rtl/stack_ram.sv
// Storage array for the stack: DEPTH words of DATA_W bits.
// It has one synchronous write port and one asynchronous read port.
// Its contents are not reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data
module stack_ram
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware operand stack that serves the controller's push, pop and tos commands.
// Function:
//   - A stack pointer tracks the number of entries (count).
//   - pop and tos return the top entry on the registered dout one cycle later.
//   - Illegal operations (push when full, read when empty) are dropped.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous reset, active high
//   bus - stack_unit_if.slave (command strobes, data and status)
// Optional feature STACK_ERR_EN adds sticky overflow and underflow flags.
// Those flags are cleared by bus.err_clr.
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  stack_unit_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;

  stack_op_t         op_c;
  logic              empty_c, full_c;
  logic              we_c;
  logic [AW-1:0]     waddr_c, top_idx_c;
  logic [DATA_W-1:0] rdata_c;

  assign op_c      = decode_op(bus.push, bus.pop, bus.tos);
  assign empty_c   = (sp_q == '0);
  assign full_c    = (sp_q == PTR_W'(DEPTH));
  // When the stack is empty this index wraps, but every path that uses it is gated by empty_c.
  assign top_idx_c = AW'(sp_q - PTR_W'(1));

  stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (bus.din),
    .raddr (top_idx_c),
    .rdata (rdata_c)
  );

  // Command execution: pointer update, storage write and read capture.
  always_comb begin
    sp_d    = sp_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    we_c    = 1'b0;
    waddr_c = AW'(sp_q);
    case (op_c)
      OP_PUSH: begin
        if (!full_c) begin
          we_c = 1'b1;
          sp_d = sp_q + PTR_W'(1);
        end
      end
      OP_POP: begin
        if (!empty_c) begin
          dout_d = rdata_c;
          vld_d  = 1'b1;
          sp_d   = sp_q - PTR_W'(1);
        end
      end
      OP_TOS: begin
        if (!empty_c) begin
          dout_d = rdata_c;
          vld_d  = 1'b1;
        end
      end
      OP_REPLACE: begin
        if (!empty_c) begin
          // The old top is read combinationally, before the write lands at the clock edge.
          dout_d  = rdata_c;
          vld_d   = 1'b1;
          we_c    = 1'b1;
          waddr_c = top_idx_c;
        end else begin
          // An empty stack cannot also be full, so this push always succeeds.
          we_c = 1'b1;
          sp_d = sp_q + PTR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.count    = sp_q;
  assign bus.empty    = empty_c;
  assign bus.full     = full_c;

`ifdef STACK_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags. A new error in the same cycle as err_clr wins over the clear.
  always_comb begin
    ovf_d = (ovf_q & ~bus.err_clr) | ((op_c == OP_PUSH) && full_c);
    udf_d = (udf_q & ~bus.err_clr) |
            (((op_c == OP_POP) || (op_c == OP_TOS) || (op_c == OP_REPLACE)) && empty_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit.
// A table of directed command vectors is applied, and each expected result is computed by hand.
// Hand-written sequences then cover the full/overflow case and the asynchronous reset case.
module tb_stack_unit;
  import stack_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;
  localparam int unsigned PW = $clog2(DP) + 1;

  logic clk = 1'b0;
  logic rst;

  stack_unit_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  stack_unit #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          push;
    logic          pop;
    logic          tos;
    logic          clr;
    logic [DW-1:0] din;
    logic [DW-1:0] e_dout;
    logic          e_vld;
    logic [PW-1:0] e_cnt;
    logic          e_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic p, input logic q, input logic t, input logic c,
                              input logic [DW-1:0] d, input logic [DW-1:0] ed,
                              input logic ev, input logic [PW-1:0] ec, input logic eu);
    vec_t v;
    v.push = p; v.pop = q; v.tos = t; v.clr = c; v.din = d;
    v.e_dout = ed; v.e_vld = ev; v.e_cnt = ec; v.e_udf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.tos  = 1'b0;
    bus.din  = '0;
`ifdef STACK_ERR_EN
    bus.err_clr = 1'b0;
`endif
  endtask

  // Drive one command for one clock, sample 1 time unit after the edge, then return the strobes to idle.
  task automatic apply(input vec_t v);
    bus.push = v.push;
    bus.pop  = v.pop;
    bus.tos  = v.tos;
    bus.din  = v.din;
`ifdef STACK_ERR_EN
    bus.err_clr = v.clr;
`endif
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic check_state(input string tag, input logic [DW-1:0] ed, input logic ev,
                             input logic [PW-1:0] ec);
    chk({tag, ".dout"},     32'(bus.dout),     32'(ed));
    chk({tag, ".dout_vld"}, 32'(bus.dout_vld), 32'(ev));
    chk({tag, ".count"},    32'(bus.count),    32'(ec));
    chk({tag, ".empty"},    32'(bus.empty),    32'(ec == '0));
    chk({tag, ".full"},     32'(bus.full),     32'(ec == PW'(DP)));
  endtask

  initial begin
    // push pop tos clr din | dout vld cnt udf
    vecs.push_back(mk(1,0,0,0,8'h11, 8'h00,0,1,0));
    vecs.push_back(mk(1,0,0,0,8'h22, 8'h00,0,2,0));
    vecs.push_back(mk(1,0,0,0,8'h33, 8'h00,0,3,0));
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h33,1,2,0));
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h22,1,1,0));
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h11,1,0,0));
    vecs.push_back(mk(1,0,0,0,8'h5A, 8'h11,0,1,0));
    vecs.push_back(mk(0,0,1,0,8'h00, 8'h5A,1,1,0));
    vecs.push_back(mk(0,0,1,0,8'h00, 8'h5A,1,1,0));
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h5A,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h5A,0,0,1));  // pop on empty
    vecs.push_back(mk(0,0,1,0,8'h00, 8'h5A,0,0,1));  // tos on empty, flag stays set
    vecs.push_back(mk(0,0,0,1,8'h00, 8'h5A,0,0,0));  // clear flags
    vecs.push_back(mk(1,0,0,0,8'h10, 8'h5A,0,1,0));
    vecs.push_back(mk(1,0,0,0,8'h20, 8'h5A,0,2,0));
    vecs.push_back(mk(1,1,0,0,8'h99, 8'h20,1,2,0));  // replace
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h99,1,1,0));
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h10,1,0,0));
    vecs.push_back(mk(1,1,0,0,8'h77, 8'h10,0,1,1));  // replace on empty acts as push
    vecs.push_back(mk(0,0,1,0,8'h00, 8'h77,1,1,1));
    vecs.push_back(mk(0,1,0,1,8'h00, 8'h77,1,0,0));  // clear with a legal pop
    vecs.push_back(mk(0,1,0,1,8'h00, 8'h77,0,0,1));  // error in the same cycle as clear
    vecs.push_back(mk(0,0,0,0,8'h00, 8'h77,0,0,1));
    vecs.push_back(mk(0,0,0,1,8'h00, 8'h77,0,0,0));
    vecs.push_back(mk(1,0,0,0,8'h01, 8'h77,0,1,0));
    vecs.push_back(mk(1,1,1,0,8'h02, 8'h01,1,1,0));  // all strobes -> replace
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h02,1,0,0));
    vecs.push_back(mk(1,0,0,0,8'h03, 8'h02,0,1,0));
    vecs.push_back(mk(1,0,0,0,8'h04, 8'h02,0,2,0));
    vecs.push_back(mk(0,1,1,0,8'h00, 8'h04,1,1,0));  // pop wins over tos
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h03,1,0,0));
    vecs.push_back(mk(1,0,1,0,8'h05, 8'h03,0,1,0));  // push wins over tos
    vecs.push_back(mk(0,1,0,0,8'h00, 8'h05,1,0,0));

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'h00, 1'b0, '0);
`ifdef STACK_ERR_EN
    chk("reset.overflow",  32'(bus.overflow),  32'd0);
    chk("reset.underflow", 32'(bus.underflow), 32'd0);
`endif
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check_state($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_vld, vecs[i].e_cnt);
`ifdef STACK_ERR_EN
      chk($sformatf("vec%0d.underflow", i), 32'(bus.underflow), 32'(vecs[i].e_udf));
      chk($sformatf("vec%0d.overflow", i),  32'(bus.overflow),  32'd0);
`endif
    end

    // Fill the stack to full, then push once more to cause an overflow.
    for (int i = 0; i < int'(DP); i++) begin
      apply(mk(1,0,0,0,DW'(i), 8'h00,0,'0,0));
      chk($sformatf("fill%0d.count", i), 32'(bus.count), 32'(i + 1));
    end
    apply(mk(1,0,0,0,8'hFF, 8'h00,0,'0,0));
    check_state("ovf_push", 8'h05, 1'b0, PW'(DP));
`ifdef STACK_ERR_EN
    chk("ovf_push.overflow", 32'(bus.overflow), 32'd1);
`endif
    apply(mk(0,1,0,0,8'h00, 8'h00,0,'0,0));
    check_state("ovf_pop", 8'h0F, 1'b1, PW'(DP - 1));
    apply(mk(1,0,0,0,8'h3C, 8'h00,0,'0,0));
    check_state("refill", 8'h0F, 1'b0, PW'(DP));
    apply(mk(1,1,0,0,8'hAA, 8'h00,0,'0,0));
    check_state("replace_full", 8'h3C, 1'b1, PW'(DP));
    apply(mk(0,1,0,0,8'h00, 8'h00,0,'0,0));
    check_state("pop_aa", 8'hAA, 1'b1, PW'(DP - 1));
    apply(mk(0,1,0,0,8'h00, 8'h00,0,'0,0));
    check_state("pop_0e", 8'h0E, 1'b1, PW'(DP - 2));
    apply(mk(1,0,0,0,8'h44, 8'h00,0,'0,0));
    apply(mk(1,0,0,0,8'h55, 8'h00,0,'0,0));
    chk("pre_rst.count", 32'(bus.count), 32'(DP));
`ifdef STACK_ERR_EN
    chk("pre_rst.overflow", 32'(bus.overflow), 32'd1);
`endif

    // Assert reset between clock edges. The outputs must clear without waiting for a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 8'h00, 1'b0, '0);
`ifdef STACK_ERR_EN
    chk("async_rst.overflow", 32'(bus.overflow), 32'd0);
`endif
    // A command that arrives while reset is held must be discarded.
    bus.push = 1'b1;
    bus.din  = 8'h66;
    @(posedge clk);
    #1;
    chk("rst_cmd.count", 32'(bus.count), 32'd0);
    idle_inputs();
    rst = 1'b0;
    apply(mk(0,1,0,0,8'h00, 8'h00,0,'0,0));
    check_state("post_rst_pop", 8'h00, 1'b0, '0);
`ifdef STACK_ERR_EN
    chk("post_rst_pop.underflow", 32'(bus.underflow), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
Hardware operand stack that services the controller's push / pop / tos command strobes on the CPU's stack interface. It holds DEPTH words, tracks the stack pointer, and returns popped or peeked data on a registered output for the datapath's stack-to-register path. It sits inside the datapath, beside the ALU operand registers A and B.

Parameters:
DATA_W, 8, word width of stack entries and data ports
DEPTH, 16, number of entries; power of two, at least 2
PTR_W, $clog2(DEPTH)+1, width of pointer/count (derived localparam, not overridable)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
push  input  1  push din onto stack this cycle
pop  input  1  remove top entry; its value appears on dout next cycle
tos  input  1  copy top entry to dout next cycle without removal
din  input  DATA_W  data to push (from memory/ALU mux)
dout  output  DATA_W  registered read data
dout_vld  output  1  one-cycle pulse: dout updated by a successful pop/tos/replace
count  output  PTR_W  current number of entries
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- Reset (async, rst=1): sp/count=0, dout=0, dout_vld=0, empty=1, full=0, error flags=0. Storage contents are not reset.
- Storage: DEPTH x DATA_W. Write is synchronous; read is combinational at index sp-1, and dout is registered.
- Commands are sampled on each rising clk. Decode priority:
  - push & pop (tos ignored) -> REPLACE.
  - otherwise push -> PUSH.
  - otherwise pop -> POP.
  - otherwise tos -> TOS.
  - otherwise NONE.
- PUSH, not full: mem[sp] <= din; sp <= sp+1; dout unchanged; dout_vld=0.
- PUSH, full: ignored, with no write and no sp change; overflow error raised.
- POP, not empty: dout <= mem[sp-1]; sp <= sp-1; dout_vld=1 next cycle.
- POP, empty: ignored; dout holds; dout_vld=0; underflow error raised.
- TOS, not empty: dout <= mem[sp-1]; sp unchanged; dout_vld=1.
- TOS, empty: same as POP on empty.
- REPLACE, not empty: dout <= old mem[sp-1]; mem[sp-1] <= din; sp unchanged; dout_vld=1. Allowed when full.
- REPLACE, empty: behaves as PUSH (dout_vld=0) and raises underflow.
- Latency:
  - Data pushed in cycle N is visible to tos/pop in cycle N+1; read-after-write forwarding is implicit via storage.
  - dout is valid one cycle after the command.
- Back-to-back pop/pop is legal; each pop returns successive entries.
- count, empty and full are combinational from sp and reflect post-update state the cycle after a command.
- Pointer never wraps: it is saturating by rule, because illegal ops are dropped.
- Reset asserted mid-sequence clears the pointer immediately. A command strobe coincident with rst is discarded.

Optional Feature:
Macro STACK_ERR_EN.
- Defined: adds ports err_clr (input 1), overflow (output 1) and underflow (output 1).
  - Both flags are sticky and set on the illegal ops above.
  - Both are cleared by err_clr=1 for one cycle or by rst.
  - If err_clr and a new error occur in the same cycle, the flag stays set.
- Undefined: these ports and flags are absent; illegal ops are silently ignored with otherwise identical behaviour.

Decomposition:
- Package stack_pkg:
  - default DATA_W / DEPTH constants.
  - typedef enum logic [2:0] stack_op_t {OP_NONE, OP_PUSH, OP_POP, OP_TOS, OP_REPLACE}.
  - the decode function mapping (push, pop, tos) to stack_op_t.
- Sub-module stack_ram: DEPTH x DATA_W array with one sync write port and one async read port; no reset.
- stack_unit holds the pointer, decode, dout register and flags.

Test Plan:
- Reset then push 0x11, 0x22, 0x33 -> count=3, empty=0. Then pop x3 -> dout 0x33, 0x22, 0x11 on successive cycles, dout_vld=1 each time, final empty=1.
- Push 0x5A, then tos twice -> dout=0x5A both times, count stays 1.
- Push DEPTH values 0..15, then push 0xFF -> full=1, count=16, overflow=1 (STACK_ERR_EN). Pop -> dout=0x0F, not 0xFF.
- Reset, then pop -> dout stays 0x00, dout_vld=0, underflow=1. Then err_clr pulse -> underflow=0.
- Push 0x10, 0x20, then push & pop with din=0x99 -> dout=0x20, count=2. Then pop -> dout=0x99.
- Push 0x44, 0x55, then assert rst asynchronously between clock edges -> count=0, dout=0 immediately without waiting for clk. Then pop -> underflow.
